seq_magnitude_comparator: RTL and testbench
===========================================

// Module: seq_magnitude_comparator
// PURPOSE
//  Parametrised, multi-cycle magnitude comparator: the N-bit successor of our 1-bit comparator.
//  Latches two WIDTH-bit operands on start, compares MSB-first CHUNK bits per cycle, exits early
//  on the first differing chunk, and returns registered one-hot equal/greater/lesser with a done pulse.
//  Used where wide compares must not sit on a single-cycle combinational path.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be >= 1
//  CHUNK  1  bits compared per cycle; must divide WIDTH exactly (elaboration error otherwise)
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  start        in   1      request a compare; accepted only when busy==0
//  a            in   WIDTH  operand A; sampled on the accepting edge only
//  b            in   WIDTH  operand B; sampled on the accepting edge only
//  signed_mode  in   1      two's-complement compare; present only with COMP_SIGNED_EN
//  busy         out  1      high while a compare is in progress
//  done         out  1      one-cycle pulse: result outputs updated this cycle
//  equal        out  1      a == b (registered)
//  greater      out  1      a > b (registered)
//  lesser       out  1      a < b (registered)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy=done=equal=greater=lesser=0; chunk index=0.
//  - States: IDLE -> COMPARE on accepted start; COMPARE -> IDLE when decided; no other transitions.
//  - IDLE: start==1 at edge E0 latches a,b (and signed_mode), sets busy=1, chunk index k=0 (MSB chunk).
//  - COMPARE, chunk k = bits [WIDTH-1-k*CHUNK -: CHUNK]:
//    chunks differ -> gt/lt per unsigned chunk compare; register result; done=1; busy=0; go IDLE.
//    chunks equal, k < WIDTH/CHUNK-1 -> k++; stay in COMPARE.
//    chunks equal, k == WIDTH/CHUNK-1 -> equal=1; done=1; busy=0; go IDLE.
//  - Latency: done high in the cycle after edge E(m+1), where m = index of the deciding chunk;
//    minimum 1 edge after E0, maximum WIDTH/CHUNK edges after E0.
//  - Results one-hot whenever done has pulsed at least once since reset; all three 0 before that.
//    Results hold until the next completion; they are NOT cleared on start.
//  - start while busy==1: ignored; no operand capture, no effect on the in-flight compare.
//  - Back-to-back: done cycle is in IDLE, so start in that cycle is accepted (1 idle-free turnaround).
//  - a/b changes while busy: no effect (operands latched).
//  - rst_n asserted mid-compare: compare abandoned, no done pulse, all outputs to reset values.
//  - WIDTH==CHUNK: single-chunk compare; done always 1 edge after E0.
// CONFIGURATION
//  COMP_SIGNED_EN defined: signed_mode port exists; when latched high, MSB of a and b are inverted
//    before compare (two's-complement ordering); all other behaviour identical.
//  COMP_SIGNED_EN undefined: no signed_mode port; operands always compared unsigned.
// STRUCTURE
//  - Package comparator_pkg: state enum (ST_IDLE, ST_COMPARE); result encoding constants
//    (RES_EQ, RES_GT, RES_LT as 3-bit one-hot {greater,equal,lesser}); chunk-count function.
//  - Sub-module comparator_chunk: combinational CHUNK-bit unsigned compare -> gt, lt.
//  - Top holds FSM, operand/index registers, result registers, done pulse.
// TESTING
//  1. Reset: rst_n=0 with start=1 -> busy=done=equal=greater=lesser=0 during and after release.
//  2. W=8,C=1: a=8'h80,b=8'h7F -> greater=1, done 1 edge after start (MSB decides).
//  3. W=8,C=1: a=b=8'hA5 -> equal=1, done exactly 8 edges after start; busy high 8 edges.
//  4. W=8,C=4: a=8'h3C,b=8'h3D -> lesser=1 after 2 edges; start pulsed mid-compare ignored.
//  5. COMP_SIGNED_EN, signed_mode=1: a=8'hFF(-1),b=8'h01 -> lesser=1; signed_mode=0 -> greater=1.
//  6. Back-to-back start on done cycle accepted; rst_n pulse mid-compare -> no done, outputs 0.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Result encoding is one-hot {greater, equal, lesser}.
package comparator_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COMPARE = 1'b1
  } state_e;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  function automatic int chunk_count(
    input int width,
    input int chunk
  );
    if (chunk < 1) return 1;
    return width / chunk;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
// Outputs are mutually exclusive; both low means the slices match.
module comparator_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit.
// Optional COMP_SIGNED_EN adds a signed_mode port (two's-complement).
module seq_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             greater,
  output logic             lesser
);
  import comparator_pkg::*;

  localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST = KW'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_magnitude_comparator: CHUNK must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    idx_q, idx_d;
  logic [2:0]       res_q, res_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] flip;
  logic             chk_gt, chk_lt;

  // Operands are shifted left as chunks match, so the live chunk is always on top
  comparator_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (a_q[WIDTH-1 -: CHUNK]),
    .b  (b_q[WIDTH-1 -: CHUNK]),
    .gt (chk_gt),
    .lt (chk_lt)
  );

  // Sign handling: inverting both MSBs maps signed order onto unsigned order
  always_comb begin
    flip = '0;
`ifdef COMP_SIGNED_EN
    flip[WIDTH-1] = signed_mode;
`endif
  end

  // FSM next state, operand walk and result capture
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a ^ flip;
          b_d     = b ^ flip;
          idx_d   = '0;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        unique case (1'b1)
          chk_gt: begin
            res_d   = RES_GT;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
          chk_lt: begin
            res_d   = RES_LT;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
          default: begin
            if (idx_q == LAST) begin
              res_d   = RES_EQ;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              idx_d = idx_q + KW'(1);
              a_d   = a_q << CHUNK;
              b_d   = b_q << CHUNK;
            end
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand, index and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= RES_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == ST_COMPARE);
  assign done    = done_q;
  assign greater = res_q[2];
  assign equal   = res_q[1];
  assign lesser  = res_q[0];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: W8/C1 and W8/C4 instances.
// Vector table plus hand sequences, scoreboard queues per instance.
module tb_seq_magnitude_comparator;

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  typedef struct {
    bit         sel;
    logic [7:0] a;
    logic [7:0] b;
    bit         sm;
    logic [2:0] res;
    int         lat;
  } vec_t;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic [7:0] a0, b0, a1, b1;
  logic sm0, sm1;
  logic busy0, done0, eq0, gt0, lt0;
  logic busy1, done1, eq1, gt1, lt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_magnitude_comparator #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start0),
    .a           (a0),
    .b           (b0),
`ifdef COMP_SIGNED_EN
    .signed_mode (sm0),
`endif
    .busy        (busy0),
    .done        (done0),
    .equal       (eq0),
    .greater     (gt0),
    .lesser      (lt0)
  );

  seq_magnitude_comparator #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .a           (a1),
    .b           (b1),
`ifdef COMP_SIGNED_EN
    .signed_mode (sm1),
`endif
    .busy        (busy1),
    .done        (done1),
    .equal       (eq1),
    .greater     (gt1),
    .lesser      (lt1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Scoreboard: pop expected result whenever an instance pulses done
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        chk("c1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("c1_result", {29'd0, gt0, eq0, lt0}, {29'd0, e.res});
        chk("c1_done_cycle", cyc, e.cyc);
        chk("c1_busy_on_done", {31'd0, busy0}, 32'd0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        chk("c4_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("c4_result", {29'd0, gt1, eq1, lt1}, {29'd0, e.res});
        chk("c4_done_cycle", cyc, e.cyc);
        chk("c4_busy_on_done", {31'd0, busy1}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {22'd0, busy0, done0, gt0, eq0, lt0,
               busy1, done1, gt1, eq1, lt1}, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after E0
  task automatic issue(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.cyc = cyc + 1 + v.lat;
    if (!v.sel) begin
      start0 = 1'b1; a0 = v.a; b0 = v.b; sm0 = v.sm;
      q0.push_back(e);
    end else begin
      start1 = 1'b1; a1 = v.a; b1 = v.b; sm1 = v.sm;
      q1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    // Operands must be latched: scramble inputs while busy
    a0 = ~a0; b0 = b0 + 8'd1; sm0 = ~sm0;
    a1 = ~a1; b1 = b1 + 8'd1; sm1 = ~sm1;
    chk(v.sel ? "c4_busy_after_start" : "c1_busy_after_start",
        {31'd0, v.sel ? busy1 : busy0}, 32'd1);
  endtask

  initial begin
    vec_t v;
    rst_n  = 1'b0;
    start0 = 1'b1; start1 = 1'b1;
    a0 = 8'h12; b0 = 8'h34; a1 = 8'h56; b1 = 8'h78;
    sm0 = 1'b0; sm1 = 1'b0;

    vecs.push_back('{1'b0, 8'h80, 8'h7F, 1'b0, R_GT, 1});
    vecs.push_back('{1'b0, 8'hA5, 8'hA5, 1'b0, R_EQ, 8});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b0, R_EQ, 8});
    vecs.push_back('{1'b0, 8'h01, 8'h00, 1'b0, R_GT, 8});
    vecs.push_back('{1'b0, 8'hFE, 8'hFF, 1'b0, R_LT, 8});
    vecs.push_back('{1'b0, 8'h10, 8'h20, 1'b0, R_LT, 3});
    vecs.push_back('{1'b0, 8'hFF, 8'h00, 1'b0, R_GT, 1});
    vecs.push_back('{1'b1, 8'h3C, 8'h3D, 1'b0, R_LT, 2});
    vecs.push_back('{1'b1, 8'h3C, 8'h3C, 1'b0, R_EQ, 2});
    vecs.push_back('{1'b1, 8'h5A, 8'h4F, 1'b0, R_GT, 1});
    vecs.push_back('{1'b1, 8'h00, 8'hF0, 1'b0, R_LT, 1});
`ifdef COMP_SIGNED_EN
    vecs.push_back('{1'b0, 8'hFF, 8'h01, 1'b1, R_LT, 1});
    vecs.push_back('{1'b0, 8'hFF, 8'h01, 1'b0, R_GT, 1});
    vecs.push_back('{1'b0, 8'h80, 8'h7F, 1'b1, R_LT, 1});
    vecs.push_back('{1'b0, 8'hFE, 8'hFF, 1'b1, R_LT, 8});
    vecs.push_back('{1'b1, 8'h80, 8'h10, 1'b1, R_LT, 1});
`endif

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    chk_all_zero("reset_hold_outputs");
    start0 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_release_outputs");

    // Vector table
    foreach (vecs[i]) begin
      issue(vecs[i]);
      wait_idle();
      @(negedge clk);
    end

    // Start pulsed while busy on the C4 instance is ignored
    v = '{1'b1, 8'h3C, 8'h3D, 1'b0, R_LT, 2};
    issue(v);
    start1 = 1'b1; a1 = 8'hFF; b1 = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk("c4_busy_mid", {31'd0, busy1}, 32'd1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("c4_idle_after_ignored_start", {31'd0, busy1}, 32'd0);
    chk("c4_result_kept", {29'd0, gt1, eq1, lt1}, {29'd0, R_LT});

    // Back-to-back: new start in the done cycle is accepted
    v = '{1'b0, 8'h80, 8'h7F, 1'b0, R_GT, 1};
    issue(v);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_first_done", {31'd0, done0}, 32'd1);
    v = '{1'b0, 8'h7F, 8'h80, 1'b0, R_LT, 1};
    issue(v);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("b2b_final_result", {29'd0, gt0, eq0, lt0}, {29'd0, R_LT});

    // Reset mid-compare: abandoned, no done, outputs cleared
    v = '{1'b0, 8'hA5, 8'hA5, 1'b0, R_EQ, 8};
    issue(v);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk_all_zero("reset_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_all_zero("reset_mid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
